// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: serial scan picks a target voice (retrigger, free, or oldest),
// then one APPLY cycle updates it; env_tick runs a linear release ramp on released voices.
module voice_allocator #(
   parameter int unsigned       VOICES       = 8,
   parameter int unsigned       NOTE_W       = 5,
   parameter int unsigned       FREQ_W       = 32,
   parameter int unsigned       VOL_W        = 32,
   parameter logic [VOL_W-1:0]  FULL_VOL     = VOL_W'(1 << 20),
   parameter logic [VOL_W-1:0]  RELEASE_STEP = VOL_W'(1 << 16),
   parameter int unsigned       AGE_W        = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             ev_valid,
   output logic                             ev_ready,
   input  logic                             ev_on,
   input  logic [NOTE_W-1:0]                ev_note,
   input  logic [FREQ_W-1:0]                ev_freq,
   input  logic                             env_tick,
   output logic [VOICES-1:0][FREQ_W-1:0]    frequencies,
   output logic [VOICES-1:0][VOL_W-1:0]     voice_volumes,
   output logic [VOICES-1:0]                voice_active,
   output logic [VOICES-1:0]                voice_held
);

   localparam int unsigned      IDX_W   = $clog2(VOICES);
   localparam logic [1:0]       S_IDLE  = 2'd0;
   localparam logic [1:0]       S_SCAN  = 2'd1;
   localparam logic [1:0]       S_APPLY = 2'd2;
   localparam logic [AGE_W-1:0] AGE_MAX = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VOICES - 1);

   logic [1:0]        r_state;
   logic              r_ready;
   logic [IDX_W-1:0]  r_idx;
   logic              r_lon;
   logic [NOTE_W-1:0] r_lnote;
   logic [FREQ_W-1:0] r_lfreq;
   logic              r_match_ok;
   logic              r_free_ok;
   logic [IDX_W-1:0]  r_match_idx;
   logic [IDX_W-1:0]  r_free_idx;
   logic [IDX_W-1:0]  r_old_idx;
   logic [AGE_W-1:0]  r_old_age;

   logic [VOICES-1:0] r_held;
   logic [VOICES-1:0] r_active;
   logic [NOTE_W-1:0] r_note [VOICES];
   logic [AGE_W-1:0]  r_age  [VOICES];
   logic [FREQ_W-1:0] r_freq [VOICES];
   logic [VOL_W-1:0]  r_vol  [VOICES];

   logic              w_accept;
   logic [IDX_W-1:0]  w_target;

   assign w_accept = ev_valid && r_ready;
   assign w_target = r_match_ok ? r_match_idx : (r_free_ok ? r_free_idx : r_old_idx);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b1;
         r_idx       <= '0;
         r_lon       <= 1'b0;
         r_lnote     <= '0;
         r_lfreq     <= '0;
         r_match_ok  <= 1'b0;
         r_free_ok   <= 1'b0;
         r_match_idx <= '0;
         r_free_idx  <= '0;
         r_old_idx   <= '0;
         r_old_age   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_SCAN;
                  r_ready     <= 1'b0;
                  r_idx       <= '0;
                  r_lon       <= ev_on;
                  r_lnote     <= ev_note;
                  r_lfreq     <= ev_freq;
                  r_match_ok  <= 1'b0;
                  r_free_ok   <= 1'b0;
                  r_match_idx <= '0;
                  r_free_idx  <= '0;
                  r_old_idx   <= '0;
                  r_old_age   <= '0;
               end
            end
            S_SCAN: begin
               if (!r_match_ok && r_active[r_idx] && (r_note[r_idx] == r_lnote)) begin
                  r_match_ok  <= 1'b1;
                  r_match_idx <= r_idx;
               end
               if (!r_free_ok && !r_active[r_idx]) begin
                  r_free_ok  <= 1'b1;
                  r_free_idx <= r_idx;
               end
               // Strict compare keeps the lowest index on equal age.
               if (r_age[r_idx] > r_old_age) begin
                  r_old_age <= r_age[r_idx];
                  r_old_idx <= r_idx;
               end
               if (r_idx == IDX_LAST) r_state <= S_APPLY;
               else                   r_idx   <= r_idx + 1'b1;
            end
            S_APPLY: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Release decay is written first so a same-cycle APPLY write to the voice overrides it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_held   <= '0;
         r_active <= '0;
         for (int unsigned v = 0; v < VOICES; v++) begin
            r_note[v] <= '0;
            r_age[v]  <= '0;
            r_freq[v] <= '0;
            r_vol[v]  <= '0;
         end
      end else begin
         for (int unsigned v = 0; v < VOICES; v++) begin
            if (env_tick && r_active[v] && !r_held[v]) begin
               if (r_vol[v] <= RELEASE_STEP) begin
                  r_vol[v]    <= '0;
                  r_active[v] <= 1'b0;
               end else begin
                  r_vol[v] <= r_vol[v] - RELEASE_STEP;
               end
            end
            if (r_state == S_APPLY) begin
               if (r_lon) begin
                  if (IDX_W'(v) == w_target) begin
                     r_freq[v]   <= r_lfreq;
                     r_vol[v]    <= FULL_VOL;
                     r_note[v]   <= r_lnote;
                     r_held[v]   <= 1'b1;
                     r_active[v] <= 1'b1;
                     r_age[v]    <= '0;
                  end else if (r_active[v] && (r_age[v] != AGE_MAX)) begin
                     r_age[v] <= r_age[v] + 1'b1;
                  end
               end else if (r_held[v] && (r_note[v] == r_lnote)) begin
                  r_held[v] <= 1'b0;
               end
            end
         end
      end
   end

   assign ev_ready     = r_ready;
   assign voice_active = r_active;
   assign voice_held   = r_held;

   always_comb begin
      frequencies   = '0;
      voice_volumes = '0;
      for (int unsigned v = 0; v < VOICES; v++) begin
         frequencies[v]   = r_freq[v];
         voice_volumes[v] = r_vol[v];
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a behavioural voice model.
module tb_voice_allocator;

   localparam int VOICES = 8;
   localparam int NOTE_W = 5;
   localparam int FREQ_W = 32;
   localparam int VOL_W  = 32;
   localparam int AGE_W  = 4;
   localparam logic [31:0] FULL = 32'h0010_0000;
   localparam logic [31:0] STEP = 32'h0001_0000;
   localparam int AGE_SAT = (1 << AGE_W) - 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic ev_valid = 1'b0;
   logic ev_on = 1'b0;
   logic [NOTE_W-1:0] ev_note = '0;
   logic [FREQ_W-1:0] ev_freq = '0;
   logic env_tick = 1'b0;
   logic ev_ready;
   logic [VOICES-1:0][FREQ_W-1:0] frequencies;
   logic [VOICES-1:0][VOL_W-1:0]  voice_volumes;
   logic [VOICES-1:0] voice_active;
   logic [VOICES-1:0] voice_held;

   voice_allocator #(
      .VOICES(VOICES), .NOTE_W(NOTE_W), .FREQ_W(FREQ_W), .VOL_W(VOL_W),
      .FULL_VOL(FULL), .RELEASE_STEP(STEP), .AGE_W(AGE_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq), .env_tick(env_tick),
      .frequencies(frequencies), .voice_volumes(voice_volumes),
      .voice_active(voice_active), .voice_held(voice_held)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: voice table, event in flight, and the active flags as seen when
   // each voice is visited (voice k is visited k+1 edges after acceptance).
   logic [31:0] m_freq [VOICES];
   logic [31:0] m_vol  [VOICES];
   int          m_age  [VOICES];
   int          m_note [VOICES];
   bit          m_held [VOICES];
   bit          m_act  [VOICES];
   bit          seen_act [VOICES];
   bit          m_ready;
   bit          m_busy;
   int          m_edges;
   bit          l_on;
   int          l_note;
   logic [31:0] l_freq;

   always @(posedge clk or negedge reset_n) begin : model
      bit acc;
      bit was_act [VOICES];
      int tgt;
      if (!reset_n) begin
         for (int v = 0; v < VOICES; v++) begin
            m_freq[v] = 0; m_vol[v] = 0; m_age[v] = 0; m_note[v] = 0;
            m_held[v] = 0; m_act[v] = 0;
         end
         m_ready = 1; m_busy = 0; m_edges = 0;
      end else begin
         acc = ev_valid && m_ready;
         for (int v = 0; v < VOICES; v++) was_act[v] = m_act[v];
         if (m_busy) begin
            m_edges++;
            if (m_edges <= VOICES) seen_act[m_edges-1] = m_act[m_edges-1];
         end
         for (int v = 0; v < VOICES; v++)
            if (env_tick && m_act[v] && !m_held[v]) begin
               if (m_vol[v] <= STEP) begin m_vol[v] = 0; m_act[v] = 0; end
               else m_vol[v] = m_vol[v] - STEP;
            end
         if (m_busy && m_edges == VOICES + 1) begin
            if (l_on) begin
               tgt = -1;
               for (int v = 0; v < VOICES; v++)
                  if (tgt < 0 && seen_act[v] && m_note[v] == l_note) tgt = v;
               for (int v = 0; v < VOICES; v++)
                  if (tgt < 0 && !seen_act[v]) tgt = v;
               if (tgt < 0) begin
                  tgt = 0;
                  for (int v = 1; v < VOICES; v++) if (m_age[v] > m_age[tgt]) tgt = v;
               end
               for (int v = 0; v < VOICES; v++) begin
                  if (v == tgt) begin
                     m_freq[v] = l_freq; m_vol[v] = FULL; m_note[v] = l_note;
                     m_held[v] = 1; m_act[v] = 1; m_age[v] = 0;
                  end else if (was_act[v] && m_age[v] < AGE_SAT) begin
                     m_age[v]++;
                  end
               end
            end else begin
               for (int v = 0; v < VOICES; v++)
                  if (m_held[v] && m_note[v] == l_note) m_held[v] = 0;
            end
            m_busy = 0; m_ready = 1;
         end
         if (acc) begin
            l_on = ev_on; l_note = int'(ev_note); l_freq = ev_freq;
            m_busy = 1; m_edges = 0; m_ready = 0;
         end
      end
   end

   always @(posedge clk) begin : compare
      logic [VOICES-1:0] e_act, e_held;
      #1;
      if (checking && reset_n) begin
         for (int v = 0; v < VOICES; v++) begin
            e_act[v] = m_act[v];
            e_held[v] = m_held[v];
         end
         check("ready", 64'(ev_ready), 64'(m_ready));
         check("active", 64'(voice_active), 64'(e_act));
         check("held", 64'(voice_held), 64'(e_held));
         for (int v = 0; v < VOICES; v++) begin
            check($sformatf("freq[%0d]", v), 64'(frequencies[v]), 64'(m_freq[v]));
            check($sformatf("vol[%0d]", v), 64'(voice_volumes[v]), 64'(m_vol[v]));
         end
      end
   end

   // Caller is at a negedge; returns at the negedge where ev_ready is high again.
   task automatic wait_ready(output int lowcnt);
      lowcnt = 0;
      while (!ev_ready && lowcnt < 50) begin
         lowcnt++;
         @(negedge clk);
      end
      if (lowcnt >= 50) check("ready_timeout", 64'(ev_ready), 64'd1);
   endtask

   task automatic send(bit on, int note, logic [31:0] f, output int lowcnt);
      int t;
      ev_valid = 1'b1; ev_on = on; ev_note = NOTE_W'(note); ev_freq = f;
      t = 0;
      while (!ev_ready && t < 50) begin t++; @(negedge clk); end
      if (t >= 50) check("accept_timeout", 64'(ev_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      ev_valid = 1'b0;
      wait_ready(lowcnt);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; ev_valid = 1'b0; env_tick = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin : stim
      int lc;
      @(negedge clk);
      do_reset();
      checking = 1'b1;

      repeat (20) begin
         check("idle_ready", 64'(ev_ready), 64'd1);
         @(negedge clk);
      end
      check("idle_vols_zero", 64'(voice_volumes == '0), 64'd1);
      check("idle_freqs_zero", 64'(frequencies == '0), 64'd1);
      check("idle_active", 64'(voice_active), 64'd0);

      send(1'b1, 0, 32'd55 << 20, lc);
      check("busy_cycles", 64'(lc), 64'd9);
      check("first_freq0", 64'(frequencies[0]), 64'h0370_0000);
      check("first_vol0", 64'(voice_volumes[0]), 64'h0010_0000);
      check("first_active", 64'(voice_active), 64'h01);
      check("first_held", 64'(voice_held), 64'h01);

      do_reset();
      for (int n = 0; n <= 8; n++) send(1'b1, n, 32'(n + 1) << 20, lc);
      check("steal_freq0", 64'(frequencies[0]), 64'(32'd9 << 20));
      check("steal_freq7", 64'(frequencies[7]), 64'(32'd8 << 20));
      check("steal_held", 64'(voice_held), 64'hFF);
      send(1'b1, 9, 32'd10 << 20, lc);
      check("steal2_freq1", 64'(frequencies[1]), 64'(32'd10 << 20));
      check("steal2_freq0", 64'(frequencies[0]), 64'(32'd9 << 20));

      do_reset();
      send(1'b1, 5, 32'h0011_1111, lc);
      send(1'b1, 5, 32'h0022_2222, lc);
      check("retrig_active", 64'(voice_active), 64'h01);
      check("retrig_freq0", 64'(frequencies[0]), 64'h0022_2222);
      send(1'b0, 5, 32'h0, lc);
      env_tick = 1'b1;
      repeat (3) @(negedge clk);
      env_tick = 1'b0;
      check("partial_decay", 64'(voice_volumes[0]), 64'h000D_0000);
      send(1'b1, 5, 32'h0033_3333, lc);
      check("retrig2_vol0", 64'(voice_volumes[0]), 64'h0010_0000);
      check("retrig2_active", 64'(voice_active), 64'h01);

      send(1'b0, 5, 32'h0, lc);
      check("off_held", 64'(voice_held), 64'h00);
      check("off_active", 64'(voice_active), 64'h01);
      env_tick = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("release_vol_%0d", k), 64'(voice_volumes[0]),
               (k < 16) ? 64'(FULL - 32'(k) * STEP) : 64'd0);
      end
      check("release_active", 64'(voice_active), 64'h00);
      @(negedge clk);
      env_tick = 1'b0;

      send(1'b1, 2, 32'h0044_4444, lc);
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 5'd3; ev_freq = 32'h0055_5555;
      @(posedge clk);
      @(negedge clk);
      ev_note = 5'd7; ev_freq = 32'h0077_7777;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_ready", 64'(ev_ready), 64'd1);
      check("rst_vols_zero", 64'(voice_volumes == '0), 64'd1);
      check("rst_freqs_zero", 64'(frequencies == '0), 64'd1);
      check("rst_active", 64'(voice_active), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev_valid = 1'b0;
      wait_ready(lc);
      check("post_rst_busy", 64'(lc), 64'd9);
      check("post_rst_freq0", 64'(frequencies[0]), 64'h0077_7777);
      check("post_rst_held", 64'(voice_held), 64'h01);

      for (int c = 0; c < 4000; c++) begin
         ev_valid = ($urandom_range(0, 2) == 0);
         ev_on    = ($urandom_range(0, 2) != 0);
         ev_note  = NOTE_W'($urandom_range(0, 11));
         ev_freq  = $urandom;
         env_tick = ($urandom_range(0, 3) == 0);
         reset_n  = ($urandom_range(0, 799) != 0);
         @(negedge clk);
      end
      reset_n = 1'b1; ev_valid = 1'b0; env_tick = 1'b0;
      repeat (12) @(negedge clk);
      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
